uart_tx_arbiter: RTL
====================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameters SHALL be:
- DATA_WIDTH, default 8, byte width.
- NUM_REQ, default 4, number of message sources.
- MAX_MSG_LEN, default 16, maximum bytes per granted message.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock; all state changes on posedge.
- reset, in, 1, synchronous, active-high.
- ena, in, 1, global enable.
- req_data, in, NUM_REQ*DATA_WIDTH, byte from each requester; slice i is requester i.
- req_valid, in, NUM_REQ, byte available per requester.
- req_last, in, NUM_REQ, current byte ends the message.
- req_ready, out, NUM_REQ, byte accepted from requester i this cycle.
- out_data, out, DATA_WIDTH, byte to TX FIFO write port.
- out_valid, out, 1, FIFO write strobe.
- out_ready, in, 1, FIFO can accept a byte.
- grant_id, out, $clog2(NUM_REQ), current or last granted requester.
- busy, out, 1, message in progress.
- trunc_err, out, 1, one-cycle pulse on a forced message end.

REQ-003 One clock only. Reset is synchronous and active-high.

Function
REQ-004 The FSM SHALL have two states: IDLE and STREAM.

REQ-005 In IDLE with ena=1 and any req_valid set, the block SHALL pick the winner round-robin. Search starts at (last_grant+1) mod NUM_REQ, upward with wrap. It SHALL then register grant_id and enter STREAM on the next edge.

REQ-006 In IDLE: out_valid=0, all req_ready=0, busy=0.

REQ-007 In STREAM with ena=1:
- out_data = req_data[grant_id]
- out_valid = req_valid[grant_id]
- req_ready[grant_id] = out_ready
- all other req_ready = 0
These paths SHALL be combinational, with zero latency.

REQ-008 A transfer SHALL occur when out_valid && out_ready. Each transfer increments byte_cnt, which has width $clog2(MAX_MSG_LEN+1).

REQ-009 On a transfer with req_last[grant_id]=1, the FSM SHALL return to IDLE and last_grant SHALL be set to grant_id.

REQ-010 On a transfer with byte_cnt == MAX_MSG_LEN-1 and req_last=0, the FSM SHALL:
- return to IDLE;
- pulse trunc_err for exactly one cycle (registered, the cycle after the transfer);
- update last_grant.

REQ-011 When req_last and the length limit coincide, the message SHALL end normally with no trunc_err.

REQ-012 byte_cnt SHALL clear on entry to STREAM.

REQ-013 Latency:
- a requester seen valid in IDLE at cycle N is granted at edge N+1;
- its first byte can transfer in cycle N+1;
- back-to-back messages are separated by at least one IDLE cycle.

REQ-014 The winner SHALL keep the grant while its req_valid is low mid-message (no timeout). Other requesters SHALL wait.

REQ-015 out_ready=0 SHALL stall the message with no state change. The block SHALL NOT drop bytes.

REQ-016 With ena=0:
- the FSM, byte_cnt and last_grant SHALL freeze;
- out_valid=0 and all req_ready=0;
- trunc_err SHALL NOT assert.

REQ-017 When only one requester is valid, it SHALL win regardless of last_grant.

REQ-018 In STREAM, busy SHALL be 1. grant_id SHALL hold its value in IDLE.

Reset
REQ-019 With reset=1 at a posedge, the block SHALL set:
- FSM = IDLE
- byte_cnt = 0
- last_grant = NUM_REQ-1, so requester 0 has first priority
- grant_id = 0
- trunc_err = 0

REQ-020 Reset SHALL override ena.

REQ-021 Reset mid-message SHALL abandon the message immediately. The next cycle SHALL have out_valid=0, and no trunc_err SHALL be raised.

Structure
REQ-022 Package uart_pkg SHALL hold the FSM state enum (IDLE, STREAM) and the DATA_WIDTH default constant.

REQ-023 Sub-module rr_arbiter SHALL be combinational:
- inputs: request vector and last_grant;
- outputs: winner index and any_req.

REQ-024 uart_tx_arbiter SHALL contain all registers and muxing.

Verification
REQ-025 Requester 2 alone sends 3 bytes 0x41, 0x42, 0x43 (last on 0x43) with out_ready=1 -> grant_id=2; exactly three out_valid pulses with those bytes in order; busy falls after 0x43; trunc_err never asserts.

REQ-026 All four requesters continuously valid, 1-byte messages, from reset -> grant order 0,1,2,3,0; one IDLE cycle between messages.

REQ-027 Requester 1 sends 20 bytes without last, MAX_MSG_LEN=16 -> 16 transfers; one trunc_err pulse; return to IDLE; remaining bytes served in a later grant.

REQ-028 out_ready held 0 for 5 cycles mid-message -> out_valid stays high; no req_ready to the requester; byte_cnt unchanged; data intact after release.

REQ-029 ena=0 for 3 cycles mid-message, then reset asserted mid-message -> no transfers while ena=0; after reset: IDLE, out_valid=0, trunc_err=0, next grant to requester 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_pkg;

    localparam int DATA_WIDTH_DEFAULT = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the search starts just above last_grant and wraps.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last_grant,
    output logic [$clog2(NUM_REQ)-1:0] winner,
    output logic                       any_req
);

    localparam int IW = $clog2(NUM_REQ);

    // Walk from the farthest offset down to +1 so the nearest requester above last_grant is written last and wins
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            int idx;
            idx = (int'(last_grant) + off) % NUM_REQ;
            if (req[idx]) begin
                winner  = IW'(idx);
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Grants one requester at a time and streams its message bytes into a TX FIFO,
// forcing a message end when MAX_MSG_LEN bytes have gone through without a last marker.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEFAULT,
    parameter int NUM_REQ     = 4,
    parameter int MAX_MSG_LEN = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ena,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy,
    output logic                          trunc_err
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_MSG_LEN + 1);

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   byte_cnt;
    logic [IW-1:0]   last_grant;
    logic [IW-1:0]   winner;
    logic            any_req;
    logic            transfer;
    logic            msg_end;
    logic            trunc_end;
    logic            sel_last;
    logic            at_limit;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_rr (
        .req       (req_valid),
        .last_grant(last_grant),
        .winner    (winner),
        .any_req   (any_req)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        out_valid  = 1'b0;
        req_ready  = '0;
        busy       = (state == STREAM);
        out_data   = req_data[grant_id*DATA_WIDTH +: DATA_WIDTH];
        transfer   = 1'b0;
        msg_end    = 1'b0;
        trunc_end  = 1'b0;
        sel_last   = req_last[grant_id];
        at_limit   = (byte_cnt == CW'(MAX_MSG_LEN - 1));
        case (state)
            IDLE: begin
                if (ena && any_req) begin
                    state_next = STREAM;
                end
            end
            STREAM: begin
                if (ena) begin
                    out_valid           = req_valid[grant_id];
                    req_ready[grant_id] = out_ready;
                    transfer            = out_valid && out_ready;
                    // A real last marker takes precedence over the length limit
                    if (transfer && (sel_last || at_limit)) begin
                        state_next = IDLE;
                        msg_end    = 1'b1;
                        trunc_end  = !sel_last;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt   <= '0;
            last_grant <= IW'(NUM_REQ - 1);
            grant_id   <= '0;
            trunc_err  <= 1'b0;
        end else begin
            trunc_err <= 1'b0;
            if (state == IDLE && ena && any_req) begin
                grant_id <= winner;
                byte_cnt <= '0;
            end
            if (transfer) begin
                if (msg_end) begin
                    last_grant <= grant_id;
                    trunc_err  <= trunc_end;
                end else begin
                    byte_cnt <= byte_cnt + CW'(1);
                end
            end
        end
    end

endmodule
